// File: rtl/music_pkg.sv
// music_pkg: shared definitions for the music player sequencer.
//   - bit positions of the 12-bit note word (note code / duration)
//   - sequencer FSM state encoding
//   - note_half_period(): base half-period table, equal-tempered scale,
//     code 1 is the lowest pitch (longest half-period), code 0 is a rest.
package music_pkg;

    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        PLAY,
        END
    } state_t;

    // 255 * 2^(-(code-1)/12), rounded; one semitone per code step.
    localparam logic [7:0] HP_TABLE [0:63] = '{
        8'd0,
        8'd255, 8'd241, 8'd227, 8'd214, 8'd202, 8'd191, 8'd180, 8'd170, 8'd161, 8'd152, 8'd143, 8'd135,
        8'd128, 8'd120, 8'd114, 8'd107, 8'd101, 8'd96,  8'd90,  8'd85,  8'd80,  8'd76,  8'd72,  8'd68,
        8'd64,  8'd60,  8'd57,  8'd54,  8'd51,  8'd48,  8'd45,  8'd43,  8'd40,  8'd38,  8'd36,  8'd34,
        8'd32,  8'd30,  8'd28,  8'd27,  8'd25,  8'd24,  8'd23,  8'd21,  8'd20,  8'd19,  8'd18,  8'd17,
        8'd16,  8'd15,  8'd14,  8'd13,  8'd13,  8'd12,  8'd11,  8'd11,  8'd10,  8'd9,   8'd9,   8'd8,
        8'd8,   8'd8,   8'd7
    };

    function automatic logic [7:0] note_half_period(input logic [5:0] code);
        return HP_TABLE[code];
    endfunction

endpackage

// File: rtl/music_player_if.sv
// music_player_if: control and ROM-bus signals of the music player.
//   play_i/stop_i/loop_i : game controller commands
//   rom_addr_o/rom_data_i: registered synchronous ROM read port
//   audio_o/busy_o/done_o: audio pin and status
// master = the player, slave = its environment (controller + ROM).
interface music_player_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 12
);
    logic                  play_i;
    logic                  stop_i;
    logic                  loop_i;
    logic [ADDR_WIDTH-1:0] rom_addr_o;
    logic [DATA_WIDTH-1:0] rom_data_i;
    logic                  audio_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  play_i, stop_i, loop_i, rom_data_i,
        output rom_addr_o, audio_o, busy_o, done_o
    );

    modport slave (
        output play_i, stop_i, loop_i, rom_data_i,
        input  rom_addr_o, audio_o, busy_o, done_o
    );
endinterface

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : run the half-period counter; when low the output is held 0
//   reload       : phase reset (counter and output cleared)
//   half_period  : cycles per output level
//   square       : registered square wave; first toggle after one full half-period
module tone_gen #(
    parameter int HP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            reload,
    input  logic [HP_W-1:0] half_period,
    output logic            square
);
    logic [HP_W-1:0] cnt;
    logic [HP_W-1:0] last;

    assign last = half_period - HP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            square <= 1'b0;
        end else if (reload || !enable) begin
            cnt    <= '0;
            square <= 1'b0;
        end else if (cnt == last) begin
            cnt    <= '0;
            square <= ~square;
        end else begin
            cnt    <= cnt + HP_W'(1);
        end
    end
endmodule

// File: rtl/music_player.sv
// music_player: ROM-driven note sequencer producing a square-wave audio output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : music_player_if.master
//                play_i/stop_i/loop_i in, rom_addr_o out, rom_data_i in,
//                audio_o, busy_o, done_o out
// Each 12-bit word is {note[5:0], duration[5:0]}; duration 0 ends the song.
// A note lasts duration*TICK_DIV cycles, preceded by a 3-cycle fetch gap.
module music_player
    import music_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 12,
    parameter int TICK_DIV   = 1_562_500,
    parameter int HP_SHIFT   = 4
) (
    input  logic clk,
    input  logic rst_n,
    music_player_if.master bus
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HP_W   = 8 + HP_SHIFT;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] word;
    logic [5:0]            word_note, word_dur;
    logic [5:0]            note, dur_rem;
    logic [TICK_W-1:0]     presc;
    logic                  done;
    logic                  busy, tone_en, tone_reload, tone_out;
    logic                  tick_wrap, note_end, addr_last, aborting;
    logic [HP_W-1:0]       half_period;

    assign word      = bus.rom_data_i;
    assign word_note = word[NOTE_MSB:NOTE_LSB];
    assign word_dur  = word[DUR_MSB:DUR_LSB];
    assign tick_wrap = (presc == TICK_LAST);
    assign note_end  = tick_wrap && (dur_rem == 6'd1);
    assign addr_last = &addr;
    assign aborting  = bus.stop_i && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (aborting) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.play_i && !bus.stop_i) next_state = FETCH;
                FETCH:   next_state = WAIT;
                WAIT:    next_state = LOAD;
                LOAD:    next_state = (word_dur == 6'd0) ? END : PLAY;
                PLAY:    if (note_end) next_state = addr_last ? END : FETCH;
                END:     next_state = bus.loop_i ? FETCH : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // The tone is disabled on the last PLAY cycle so audio is already 0
    // in the first cycle after PLAY, whatever the exit reason.
    always_comb begin
        busy        = (state != IDLE);
        tone_en     = (state == PLAY) && (next_state == PLAY) && (note != 6'd0);
        tone_reload = (state == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            note    <= '0;
            dur_rem <= '0;
            presc   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (aborting) begin
                done <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.play_i && !bus.stop_i) addr <= '0;
                    LOAD: if (word_dur != 6'd0) begin
                        note    <= word_note;
                        dur_rem <= word_dur;
                        presc   <= '0;
                    end
                    PLAY: if (tick_wrap) begin
                        presc   <= '0;
                        dur_rem <= dur_rem - 6'd1;
                        // at all ones the song ends instead, so no wrap
                        if (dur_rem == 6'd1 && !addr_last) addr <= addr + ADDR_WIDTH'(1);
                    end else begin
                        presc   <= presc + TICK_W'(1);
                    end
                    END: if (bus.loop_i) addr <= '0;
                         else            done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign half_period = HP_W'(note_half_period(note)) << HP_SHIFT;

    tone_gen #(.HP_W(HP_W)) u_tone (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (tone_en),
        .reload     (tone_reload),
        .half_period(half_period),
        .square     (tone_out)
    );

    assign bus.rom_addr_o = addr;
    assign bus.audio_o    = tone_out;
    assign bus.busy_o     = busy;
    assign bus.done_o     = done;
endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Sequencer that consumes note words from the music ROM's registered synchronous read port and produces a square-wave audio output.
- Drives the ROM address, decodes each 12-bit word into pitch and duration, times the note, then fetches the next word.
- Sits between the ROM and the audio output pin; the game controller controls it through play/stop/loop.

Parameters:
- ADDR_WIDTH, 10, ROM address width; song length up to 2**ADDR_WIDTH words.
- DATA_WIDTH, 12, ROM word width; fixed format below, must be 12.
- TICK_DIV, 1_562_500, clock cycles per duration tick.
- HP_SHIFT, 4, left shift applied to the table half-period (coarse pitch scaling).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- play_i  input  1  one-cycle start pulse; accepted only in IDLE.
- stop_i  input  1  abort; returns to IDLE next cycle; wins over play_i.
- loop_i  input  1  sampled at end of song; 1 restarts at address 0.
- rom_addr_o  output  ADDR_WIDTH  registered ROM address.
- rom_data_i  input  DATA_WIDTH  ROM data, valid 1 clk after address is sampled.
- audio_o  output  1  square-wave audio.
- busy_o  output  1  high in any state except IDLE.
- done_o  output  1  one-cycle pulse on non-looping end of song or stop.

Behaviour:
- Reset: asynchronous, active-low. All state clears immediately. Clock is clk.
- Reset values: rom_addr_o=0, audio_o=0, busy_o=0, done_o=0, FSM=IDLE, all counters 0.
- Word format:
  - [11:6] note code; 0 = rest, 1..63 index the half-period table.
  - [5:0] duration in ticks; 0x000 = end-of-song marker.
  - Nonzero note with zero duration is also treated as end of song.
- ROM timing: rom_addr_o is registered at edge N. The ROM registers data at edge N+1. The FSM samples rom_data_i at edge N+2.
- FSM states:
  - IDLE: on play_i, rom_addr_o<=0 and go to FETCH.
  - FETCH: go to WAIT. The address has been stable for one edge.
  - WAIT: go to LOAD.
  - LOAD: sample rom_data_i.
    - If duration==0, go to END.
    - Otherwise latch note and duration, clear the tick prescaler and tone counter, and go to PLAY.
  - PLAY: count ticks. The prescaler counts 0..TICK_DIV-1; its wrap decrements remaining duration.
    - When remaining reaches 0 on a wrap:
      - If rom_addr_o is all ones, go to END.
      - Otherwise rom_addr_o<=rom_addr_o+1 and go to FETCH.
  - END: if loop_i=1, rom_addr_o<=0 and go to FETCH. Otherwise pulse done_o and go to IDLE.
- Note gap: inter-note gap is 3 cycles (FETCH, WAIT, LOAD). audio_o is forced 0 in IDLE, FETCH, WAIT, LOAD and END.
- Tone: in PLAY with note!=0, a half-period counter counts to (table[note] << HP_SHIFT) - 1, then toggles audio_o and reloads. The first toggle occurs after one full half-period. Rest (note==0) keeps audio_o=0.
- stop_i in any non-IDLE state:
  - Next state is IDLE, audio_o<=0, done_o pulses one cycle.
  - rom_addr_o holds its value.
  - stop_i in IDLE does nothing.
- Simultaneous events: play_i with stop_i → stop wins. play_i while busy is ignored.
- busy_o is combinational from state (!=IDLE). done_o is registered.
- Widths: tick prescaler ceil(log2(TICK_DIV)) bits. Duration counter 6 bits. Half-period counter 8+HP_SHIFT bits. Address increment is only reached below all ones, so it never wraps.

Decomposition:
- Package music_pkg:
  - word field positions (NOTE_MSB=11, NOTE_LSB=6, DUR_MSB=5, DUR_LSB=0);
  - FSM state enum (IDLE, FETCH, WAIT, LOAD, PLAY, END);
  - function note_half_period(6-bit code) returning the 8-bit base half-period table (equal-tempered scale, code 1 = lowest).
- Sub-module tone_gen:
  - inputs: enable, reload (phase reset), half_period.
  - output: square wave.
  - Instantiated once.

Test Plan (TICK_DIV=4, HP_SHIFT=0, bench ROM model with 1-cycle registered read):
- ROM {0x045, 0x000}, play_i pulse:
  - addr 0 is sampled 2 edges after FETCH entry;
  - PLAY lasts 5×4=20 cycles and audio_o toggles every table[1] cycles;
  - END is then reached, done_o pulses once, and busy_o falls.
- ROM {0x003 (rest, 3 ticks), 0x000} → audio_o stays 0 for the whole song, and PLAY lasts 12 cycles.
- ROM {0x081, 0x0C1, 0x000} with loop_i=1 → addresses sequence 0,1,2,0,1,2…; there are 3 gap cycles between notes; done_o never pulses.
- stop_i asserted mid-PLAY on the second note:
  - next cycle state is IDLE, audio_o=0, done_o=1 for one cycle, rom_addr_o=1.
  - A subsequent play_i restarts at address 0.
- play_i and stop_i in the same cycle in IDLE → stays IDLE. play_i during PLAY → ignored, with no address change.
- rst_n low mid-PLAY (asynchronous, between edges) → all outputs 0 immediately. After release the block waits in IDLE until play_i.
- ADDR_WIDTH=2, ROM full of nonzero words, loop_i=0 → plays addresses 0..3 and then ENDs, with no wrap to 0.
